// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device command sender: clock inhibit, request-to-send, bit shifting on
// device clock falls, ACK check and inter-edge timeout. Drives the pads through open-drain enables.
module ps2_host_transmitter #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] tx_data_i,
  input  logic       tx_start_i,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       tx_error_o,
  output logic       rx_block_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_drive_low_o,
  output logic       ps2_data_drive_low_o
);

  localparam int unsigned MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                       : TIMEOUT_CYCLES;
  localparam int unsigned CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK_WAIT, S_WAIT_IDLE, S_DONE, S_ERROR
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    data_q, data_d;
  logic [1:0]    clk_s_q, data_s_q;
  logic          clk_prev_q;
  logic          clk_drv_q, clk_drv_d;
  logic          data_drv_q, data_drv_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic clk_sync, data_sync, fall, bit_val;

  assign clk_sync  = clk_s_q[1];
  assign data_sync = data_s_q[1];
  assign fall      = clk_prev_q & ~clk_sync;

  // Value to drive for the current bit index: data LSB first, then ~parity (odd), then released stop.
  always_comb begin
    bit_val = 1'b0;
    if (bit_idx_q < 4'd8) begin
      bit_val = ~data_q[bit_idx_q[2:0]];
    end else if (bit_idx_q == 4'd8) begin
      bit_val = ^data_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    data_drv_d = data_drv_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d      = '0;
        data_drv_d = 1'b0;
        if (tx_start_i) begin
          data_d  = tx_data_i;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        data_drv_d = 1'b0;
        if (cnt_q == INH_LAST) begin
          cnt_d      = '0;
          data_drv_d = 1'b1;
          state_d    = S_REQ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_REQ: begin
        bit_idx_d = '0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (fall) begin
          data_drv_d = bit_val;
          bit_idx_d  = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd9) begin
            state_d = S_ACK_WAIT;
          end
        end
      end
      S_ACK_WAIT: begin
        if (fall) begin
          state_d = data_sync ? S_ERROR : S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          state_d = S_DONE;
        end
      end
      S_DONE, S_ERROR: begin
        cnt_d      = '0;
        data_drv_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-edge watchdog: any device clock fall restarts it; expiry overrides the normal transition.
    if (state_q inside {S_REQ, S_SHIFT, S_ACK_WAIT, S_WAIT_IDLE}) begin
      if (fall) begin
        cnt_d = '0;
      end else if (cnt_q == TO_LAST) begin
        state_d = S_ERROR;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (state_d inside {S_IDLE, S_DONE, S_ERROR}) begin
      data_drv_d = 1'b0;
    end
    clk_drv_d = (state_d == S_INHIBIT);
    busy_d    = state_d inside {S_INHIBIT, S_REQ, S_SHIFT, S_ACK_WAIT, S_WAIT_IDLE};
    done_d    = (state_d == S_DONE);
    error_d   = (state_d == S_ERROR);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      data_q     <= '0;
      clk_s_q    <= 2'b11;
      data_s_q   <= 2'b11;
      clk_prev_q <= 1'b1;
      clk_drv_q  <= 1'b0;
      data_drv_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      clk_s_q    <= {clk_s_q[0], ps2_clk_i};
      data_s_q   <= {data_s_q[0], ps2_data_i};
      clk_prev_q <= clk_sync;
      clk_drv_q  <= clk_drv_d;
      data_drv_q <= data_drv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign tx_busy_o            = busy_q;
  assign rx_block_o           = busy_q;
  assign tx_done_o            = done_q;
  assign tx_error_o           = error_q;
  assign ps2_clk_drive_low_o  = clk_drv_q;
  assign ps2_data_drive_low_o = data_drv_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: open-drain bus plus a PS/2 device model that clocks frames,
// reads bits on its rising edges and ACKs or NACKs; expectations come from a frame model.
module tb_ps2_host_transmitter;

  localparam int INH  = 40;
  localparam int TO   = 300;
  localparam int HALF = 20;

  logic       clk, rst_n, tx_start;
  logic [7:0] tx_data;
  logic       tx_busy, tx_done, tx_error, rx_block;
  logic       drv_clk, drv_data;
  logic       dev_clk_low, dev_data_low;
  logic       bus_clk, bus_data;

  assign bus_clk  = ~(drv_clk | dev_clk_low);
  assign bus_data = ~(drv_data | dev_data_low);

  ps2_host_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data), .tx_start_i(tx_start),
    .tx_busy_o(tx_busy), .tx_done_o(tx_done), .tx_error_o(tx_error), .rx_block_o(rx_block),
    .ps2_clk_i(bus_clk), .ps2_data_i(bus_data),
    .ps2_clk_drive_low_o(drv_clk), .ps2_data_drive_low_o(drv_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0;
  int both_low = 0, rx_mismatch = 0, frames = 0;
  int fall11_cyc = 0, rel_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done) begin done_cnt++; done_cyc = cyc; end
    if (tx_error) begin err_cnt++; err_cyc = cyc; end
    if (drv_clk && drv_data) both_low++;
    if (rx_block !== tx_busy) rx_mismatch++;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog cycles=%0d limit=90000", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Frame as the device should see it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    int ones = 0;
    logic [10:0] f;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    f[0]    = 1'b0;
    f[8:1]  = b;
    f[9]    = ((ones % 2) == 0);
    f[10]   = 1'b1;
    return f;
  endfunction

  task automatic dev_frame(input bit nack, output logic [10:0] bits, output bit ok);
    int n = 0;
    bits = '0;
    ok   = 1'b0;
    while (!(drv_data === 1'b1 && drv_clk === 1'b0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) return;
    ok = 1'b1;
    repeat (HALF) @(negedge clk);
    bits[0] = bus_data;
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF / 2) @(negedge clk);
      bits[k] = bus_data;
      repeat (HALF / 2) @(negedge clk);
    end
    if (!nack) dev_data_low = 1'b1;
    repeat (HALF / 2) @(negedge clk);
    dev_clk_low = 1'b1;
    fall11_cyc  = cyc;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_data_low = 1'b0;
    rel_cyc      = cyc;
  endtask

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    frames++;
  endtask

  task automatic run_frame(input logic [7:0] b, input bit nack, output logic [10:0] bits,
                           output int dd, output int de);
    int d0 = done_cnt, e0 = err_cnt;
    bit ok;
    start_tx(b);
    dev_frame(nack, bits, ok);
    check("rts_seen", 32'(ok), 32'd1);
    for (int n = 0; n < 60 && done_cnt == d0 && err_cnt == e0; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    dd = done_cnt - d0;
    de = err_cnt - e0;
    if (!nack && dd == 1)
      check("done_after_bus_idle", 32'(done_cyc > rel_cyc && done_cyc <= rel_cyc + 8), 32'd1);
    if (nack && de == 1)
      check("error_at_fall11", 32'(err_cyc > fall11_cyc && err_cyc <= fall11_cyc + 8), 32'd1);
    check("lines_released", {30'd0, drv_clk, drv_data}, 32'd0);
    check("busy_dropped", 32'(tx_busy), 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         nack;
    bit         exp_par;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [10:0] bits;
    int dd, de, d0, busy_after, n, t0, e0;
    bit ok;

    rst_n = 1'b0; tx_start = 1'b0; tx_data = 8'h00;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_outputs", {27'd0, drv_clk, drv_data, tx_busy, tx_done, tx_error}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_outputs", {27'd0, drv_clk, drv_data, tx_busy, tx_done, tx_error}, 32'd0);

    // Reset mid-SHIFT: after the 4th fall 0x30 has bit3=0, so the data line is held low.
    start_tx(8'h30);
    n = 0;
    while (!(drv_data === 1'b1 && drv_clk === 1'b0) && n < 500) begin @(negedge clk); n++; end
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      dev_clk_low = 1'b1; repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0; repeat (HALF) @(negedge clk);
    end
    dev_clk_low = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_shift_data_low", 32'(drv_data), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_release", {29'd0, drv_clk, drv_data, tx_busy}, 32'd0);
    dev_clk_low = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    vecs[0] = '{8'hED, 1'b0, 1'b1};
    vecs[1] = '{8'h00, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 1'b0, 1'b1};
    vecs[3] = '{8'h01, 1'b0, 1'b0};
    vecs[4] = '{8'hA5, 1'b1, 1'b1};
    vecs[5] = '{8'hF4, 1'b0, 1'b0};
    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].data, vecs[v].nack, bits, dd, de);
      check("vec_start", 32'(bits[0]), 32'd0);
      check("vec_data", 32'(bits[8:1]), 32'(vecs[v].data));
      check("vec_parity", 32'(bits[9]), 32'(vecs[v].exp_par));
      check("vec_stop", 32'(bits[10]), 32'd1);
      check("vec_done", dd, vecs[v].nack ? 32'd0 : 32'd1);
      check("vec_error", de, vecs[v].nack ? 32'd1 : 32'd0);
    end

    for (int r = 0; r < 6; r++) begin
      logic [7:0] b;
      bit nk;
      b  = 8'($urandom_range(0, 255));
      nk = ($urandom_range(0, 3) == 0);
      run_frame(b, nk, bits, dd, de);
      check("rand_frame", 32'(bits), 32'(model_frame(b)));
      check("rand_outcome", {dd[15:0], de[15:0]}, nk ? 32'h0000_0001 : 32'h0001_0000);
    end

    // tx_start hammered with 0x55 while 0xED is in flight, including the DONE cycle.
    d0 = done_cnt;
    @(negedge clk);
    tx_data = 8'hED; tx_start = 1'b1;
    frames++;
    fork
      dev_frame(1'b0, bits, ok);
      begin
        for (int k = 0; k < 1500; k++) begin
          @(negedge clk);
          if (tx_done) break;
          tx_data  = 8'h55;
          tx_start = 1'b1;
        end
        tx_start = 1'b0;
      end
    join
    busy_after = 0;
    repeat (150) begin @(negedge clk); if (tx_busy) busy_after++; end
    check("busy_test_frame", 32'(bits), 32'(model_frame(8'hED)));
    check("busy_test_done", done_cnt - d0, 32'd1);
    check("busy_test_no_restart", busy_after, 32'd0);

    // Device never clocks: abort TO cycles after REQ entry.
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h12);
    n = 0;
    while (!(drv_data === 1'b1) && n < 500) begin @(negedge clk); n++; end
    t0 = cyc;
    n = 0;
    while (err_cnt == e0 && n < 2 * TO) begin @(negedge clk); n++; end
    @(negedge clk);
    check("timeout_seen", err_cnt - e0, 32'd1);
    check("timeout_latency", 32'((err_cyc - t0 >= TO - 1) && (err_cyc - t0 <= TO + 1)), 32'd1);
    check("timeout_released", {29'd0, drv_clk, drv_data, tx_busy}, 32'd0);
    check("timeout_no_done", done_cnt - d0, 32'd0);

    run_frame(8'hF4, 1'b0, bits, dd, de);
    check("recover_frame", 32'(bits), 32'(model_frame(8'hF4)));
    check("recover_done", dd, 32'd1);

    check("both_low_bound", 32'(both_low <= frames), 32'd1);
    check("rx_block_eq_busy", rx_mismatch, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
